// File: rtl/mux_pkg.sv
// Shared types and defaults for the stream mux/demux family.
package mux_pkg;

  // Packet-level state of the demultiplexer.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } demux_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  // A register slot can take a new beat when it is empty or being drained now.
  function automatic logic slot_can_load(input logic valid, input logic ready);
    return (~valid) | ready;
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// One valid/ready register stage carrying data plus an end-of-packet flag.
// The output side is fully registered; only slot_ready looks at out_ready.
module stream_reg_slice
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  output logic             slot_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;
  logic             last_r;

  // Slot register: load on push (also covers pop+push), clear on pop, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {WIDTH{1'b0}};
      last_r  <= 1'b0;
    end else if (push) begin
      valid_r <= 1'b1;
      data_r  <= push_data;
      last_r  <= push_last;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Readiness to accept a beat is combinational from the downstream ready.
  always_comb begin
    slot_ready = slot_can_load(valid_r, out_ready);
  end

  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign out_last  = last_r;

endmodule

// File: rtl/demux1t2_stream.sv
// Registered 1-to-2 stream demultiplexer with per-packet lane select and
// per-lane delivered-packet counters.
module demux1t2_stream
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             s,
  output logic [WIDTH-1:0] O0_data,
  output logic             O0_valid,
  output logic             O0_last,
  input  logic             O0_ready,
  output logic [WIDTH-1:0] O1_data,
  output logic             O1_valid,
  output logic             O1_last,
  input  logic             O1_ready,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  demux_state_t     state_r;
  demux_state_t     state_nxt_s;
  logic             sel_q_r;
  logic             sel_q_nxt_s;
  logic             sel_eff_s;
  logic             slot_ready0_s;
  logic             slot_ready1_s;
  logic             accept_s;
  logic             push0_s;
  logic             push1_s;
  logic             done0_s;
  logic             done1_s;
  logic [CNT_W-1:0] cnt0_r;
  logic [CNT_W-1:0] cnt1_r;

  // Lane decode: s is only honoured on the first beat; the unselected lane never stalls input.
  always_comb begin
    sel_eff_s = (state_r == IDLE) ? s : sel_q_r;
    if (sel_eff_s) begin
      in_ready = slot_ready1_s;
    end else begin
      in_ready = slot_ready0_s;
    end
    accept_s = in_valid & in_ready;
    push0_s  = accept_s & ~sel_eff_s;
    push1_s  = accept_s &  sel_eff_s;
  end

  // Packet FSM next state and select latch: enter PKT on a non-last first beat, leave on last.
  always_comb begin
    state_nxt_s = state_r;
    sel_q_nxt_s = sel_q_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !in_last) begin
          state_nxt_s = PKT;
          sel_q_nxt_s = s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PKT: begin
        if (accept_s && in_last) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PKT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        sel_q_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state and latched select; reset discards any packet in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sel_q_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      sel_q_r <= sel_q_nxt_s;
    end
  end

  stream_reg_slice #(
    .WIDTH(WIDTH)
  ) u_lane0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push0_s),
    .push_data  (in_data),
    .push_last  (in_last),
    .slot_ready (slot_ready0_s),
    .out_data   (O0_data),
    .out_valid  (O0_valid),
    .out_last   (O0_last),
    .out_ready  (O0_ready)
  );

  stream_reg_slice #(
    .WIDTH(WIDTH)
  ) u_lane1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push1_s),
    .push_data  (in_data),
    .push_last  (in_last),
    .slot_ready (slot_ready1_s),
    .out_data   (O1_data),
    .out_valid  (O1_valid),
    .out_last   (O1_last),
    .out_ready  (O1_ready)
  );

  // A packet is delivered when its last beat leaves the lane register.
  always_comb begin
    done0_s = O0_valid & O0_ready & O0_last;
    done1_s = O1_valid & O1_ready & O1_last;
  end

  // Per-lane delivered-packet counters, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_r <= {CNT_W{1'b0}};
      cnt1_r <= {CNT_W{1'b0}};
    end else begin
      if (done0_s) begin
        cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt0_r <= cnt0_r;
      end
      if (done1_s) begin
        cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt1_r <= cnt1_r;
      end
    end
  end

  assign busy     = (state_r == PKT);
  assign pkt_cnt0 = cnt0_r;
  assign pkt_cnt1 = cnt1_r;

endmodule

// File: tb/tb_demux1t2_stream.sv
// Self-checking bench for demux1t2_stream: directed scenarios plus random
// traffic, all compared against a lane/packet-level reference model.
module tb_demux1t2_stream;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          s = 1'b0;
  logic [W-1:0]  O0_data;
  logic          O0_valid;
  logic          O0_last;
  logic          O0_ready = 1'b0;
  logic [W-1:0]  O1_data;
  logic          O1_valid;
  logic          O1_last;
  logic          O1_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] pkt_cnt0;
  logic [CW-1:0] pkt_cnt1;

  int checks = 0;
  int errors = 0;

  // reference model: one pending beat per lane, packet state, delivered counts
  logic          m_v   [2];
  logic [W-1:0]  m_d   [2];
  logic          m_l   [2];
  logic [CW-1:0] m_cnt [2];
  logic          m_busy;
  logic          m_selq;

  demux1t2_stream #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .s        (s),
    .O0_data  (O0_data),
    .O0_valid (O0_valid),
    .O0_last  (O0_last),
    .O0_ready (O0_ready),
    .O1_data  (O1_data),
    .O1_valid (O1_valid),
    .O1_last  (O1_last),
    .O1_ready (O1_ready),
    .busy     (busy),
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int x = 0; x < 2; x++) begin
      m_v[x]   = 1'b0;
      m_d[x]   = '0;
      m_l[x]   = 1'b0;
      m_cnt[x] = '0;
    end
    m_busy = 1'b0;
    m_selq = 1'b0;
  endtask

  task automatic check_outputs();
    check_val("o0_valid", {31'd0, O0_valid}, {31'd0, m_v[0]});
    check_val("o1_valid", {31'd0, O1_valid}, {31'd0, m_v[1]});
    if (m_v[0]) begin
      check_val("o0_data", {24'd0, O0_data}, {24'd0, m_d[0]});
      check_val("o0_last", {31'd0, O0_last}, {31'd0, m_l[0]});
    end
    if (m_v[1]) begin
      check_val("o1_data", {24'd0, O1_data}, {24'd0, m_d[1]});
      check_val("o1_last", {31'd0, O1_last}, {31'd0, m_l[1]});
    end
    check_val("busy", {31'd0, busy}, {31'd0, m_busy});
    check_val("pkt_cnt0", {16'd0, pkt_cnt0}, {16'd0, m_cnt[0]});
    check_val("pkt_cnt1", {16'd0, pkt_cnt1}, {16'd0, m_cnt[1]});
  endtask

  // one clock cycle: drive inputs, check in_ready, clock, advance model, check outputs
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic l,
                       input logic sel, input logic r0, input logic r1, output logic acc);
    logic e_sel;
    logic e_rdy;
    logic rdy [2];
    logic fire;
    in_valid = v; in_data = d; in_last = l; s = sel; O0_ready = r0; O1_ready = r1;
    #1;
    rdy[0] = r0;
    rdy[1] = r1;
    e_sel = m_busy ? m_selq : sel;
    e_rdy = ~m_v[e_sel] | rdy[e_sel];
    check_val("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
    acc = v & e_rdy;
    @(posedge clk);
    #1;
    for (int x = 0; x < 2; x++) begin
      fire = m_v[x] & rdy[x];
      if (fire && m_l[x]) m_cnt[x] = m_cnt[x] + 1'b1;
      if (acc && (e_sel == x[0])) begin
        m_v[x] = 1'b1; m_d[x] = d; m_l[x] = l;
      end else if (fire) begin
        m_v[x] = 1'b0;
      end
    end
    if (acc) begin
      if (!m_busy && !l) begin
        m_busy = 1'b1;
        m_selq = sel;
      end else if (m_busy && l) begin
        m_busy = 1'b0;
      end
    end
    check_outputs();
  endtask

  logic acc;

  initial begin
    model_reset();
    #12;
    // reset state
    check_val("rst_o0_valid", {31'd0, O0_valid}, 32'd0);
    check_val("rst_o1_valid", {31'd0, O1_valid}, 32'd0);
    check_val("rst_o0_data", {24'd0, O0_data}, 32'd0);
    check_val("rst_o0_last", {31'd0, O0_last}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_cnt0", {16'd0, pkt_cnt0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: three-beat packet to lane 0
    cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    check_val("t1_acc1", {31'd0, acc}, 32'd1);
    check_val("t1_o0_a1", {24'd0, O0_data}, 32'hA1);
    cycle(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    cycle(1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, acc);
    check_val("t1_o0_last", {31'd0, O0_last}, 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    check_val("t1_cnt0", {16'd0, pkt_cnt0}, 32'd1);

    // 2: s toggles mid-packet, beats stay on lane 0
    cycle(1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    cycle(1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 1'b1, acc);
    check_val("t2_busy", {31'd0, busy}, 32'd1);
    check_val("t2_o0_b2", {24'd0, O0_data}, 32'hB2);
    cycle(1'b1, 8'hB3, 1'b1, 1'b1, 1'b1, 1'b1, acc);
    check_val("t2_busy_end", {31'd0, busy}, 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    check_val("t2_cnt0", {16'd0, pkt_cnt0}, 32'd2);
    check_val("t2_cnt1", {16'd0, pkt_cnt1}, 32'd0);

    // 3: lane 1 stalled, then lane-0 packet right after lane-1 last
    cycle(1'b1, 8'hC1, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'hC2, 1'b1, 1'b0, 1'b1, 1'b0, acc);
      check_val("t3_stall_acc", {31'd0, acc}, 32'd0);
      check_val("t3_hold_data", {24'd0, O1_data}, 32'hC1);
    end
    cycle(1'b1, 8'hC2, 1'b1, 1'b0, 1'b1, 1'b1, acc);
    check_val("t3_acc_c2", {31'd0, acc}, 32'd1);
    cycle(1'b1, 8'hD1, 1'b1, 1'b0, 1'b1, 1'b1, acc);
    check_val("t3_acc_d1", {31'd0, acc}, 32'd1);
    check_val("t3_o0_d1", {24'd0, O0_data}, 32'hD1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, acc);

    // 4: back-to-back single-beat packets alternating lanes
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 8'h40 + i[7:0], 1'b1, i[0], 1'b1, 1'b1, acc);
      check_val("t4_acc", {31'd0, acc}, 32'd1);
      check_val("t4_idle", {31'd0, busy}, 32'd0);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    check_val("t4_cnt0", {16'd0, pkt_cnt0}, 32'd5);
    check_val("t4_cnt1", {16'd0, pkt_cnt1}, 32'd3);

    // 6: reset mid-packet with O0 holding a beat
    cycle(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    check_val("t6_pre_valid", {31'd0, O0_valid}, 32'd1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_valid", {31'd0, O0_valid}, 32'd0);
    check_val("t6_rst_busy", {31'd0, busy}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 8'hF1, 1'b0, 1'b1, 1'b1, 1'b1, acc);
    check_val("t6_new_lane1", {31'd0, O1_valid}, 32'd1);
    cycle(1'b1, 8'hF2, 1'b1, 1'b0, 1'b1, 1'b1, acc);
    check_val("t6_f2_lane1", {24'd0, O1_data}, 32'hF2);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, acc);

    // 5: drive lane-1 counter up to all-ones, then one more packet wraps it
    for (int i = 0; i < 65534; i++) begin
      cycle(1'b1, i[7:0], 1'b1, 1'b1, 1'b1, 1'b1, acc);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    check_val("t5_full", {16'd0, pkt_cnt1}, 32'hFFFF);
    cycle(1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, acc);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    check_val("t5_wrap", {16'd0, pkt_cnt1}, 32'd0);

    // random traffic with gaps, stalls and mid-packet select changes
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
            1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, acc);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
